// File: rtl/qpsk_frame_ctrl.sv
// qpsk_frame_ctrl: frames a payload into QPSK symbol pairs {I,Q} paced at one
// symbol slot every SPS clocks. An optional alternating 11/00 preamble of
// PRE_LEN symbols is emitted first when QPSK_FRAME_PREAMBLE_EN is defined;
// without the macro a valid start goes straight to the payload.
// A due slot that cannot issue (downstream not ready, or no payload byte yet)
// stalls the slot counter at 0 so no symbol is lost or repeated.
module qpsk_frame_ctrl #(
    parameter int SPS     = 4,
    parameter int PRE_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_len,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_data_ready,
    input  logic       i_mod_ready,
    output logic       o_I,
    output logic       o_Q,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_done
);

`ifdef QPSK_FRAME_PREAMBLE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    localparam int CW = $clog2(SPS);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DONE} state_t;

    state_t      state_reg;
    logic [CW-1:0] slot_reg;
    logic [7:0]  len_reg;
    logic [6:0]  pre_cnt_reg;
    logic [7:0]  sr_reg;
    logic        sr_full_reg;
    logic [1:0]  sym_idx_reg;
    logic [7:0]  bytes_acc_reg;
    logic [7:0]  bytes_out_reg;

    logic due;
    logic pre_issue;
    logic pay_issue;
    logic issue;
    logic accept;

    assign due          = (slot_reg == '0);
    assign pre_issue    = (state_reg == PREAMBLE) && due && i_mod_ready;
    assign pay_issue    = (state_reg == PAYLOAD) && due && i_mod_ready && sr_full_reg;
    assign issue        = pre_issue || pay_issue;
    assign o_data_ready = (state_reg == PAYLOAD) && !sr_full_reg && (bytes_acc_reg < len_reg);
    assign accept       = o_data_ready && i_data_valid;
    assign o_busy       = (state_reg != IDLE);

    // Slot counter: free-runs 0..SPS-1 while framing, parks at 0 on a stalled due slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (state_reg == IDLE) begin
            slot_reg <= '0;
        end else if (due && !issue) begin
            slot_reg <= '0;
        end else if (slot_reg == CW'(SPS - 1)) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_reg + 1'b1;
        end
    end

    // Frame FSM with registered symbol, strobe and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            pre_cnt_reg   <= '0;
            sr_reg        <= '0;
            sr_full_reg   <= 1'b0;
            sym_idx_reg   <= '0;
            bytes_acc_reg <= '0;
            bytes_out_reg <= '0;
            o_I           <= 1'b0;
            o_Q           <= 1'b0;
            o_valid       <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_valid <= issue;
            o_done  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start && (i_len != 8'd0)) begin
                        len_reg       <= i_len;
                        pre_cnt_reg   <= '0;
                        sr_full_reg   <= 1'b0;
                        sym_idx_reg   <= '0;
                        bytes_acc_reg <= '0;
                        bytes_out_reg <= '0;
                        state_reg     <= PRE_EN ? PREAMBLE : PAYLOAD;
                    end
                end
                PREAMBLE: begin
                    if (pre_issue) begin
                        // Even-numbered preamble symbols are 11, odd ones 00.
                        o_I         <= ~pre_cnt_reg[0];
                        o_Q         <= ~pre_cnt_reg[0];
                        pre_cnt_reg <= pre_cnt_reg + 1'b1;
                        if (pre_cnt_reg == 7'(PRE_LEN - 1)) begin
                            state_reg <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        sr_reg        <= i_data;
                        sr_full_reg   <= 1'b1;
                        bytes_acc_reg <= bytes_acc_reg + 1'b1;
                    end
                    if (pay_issue) begin
                        o_I         <= sr_reg[7];
                        o_Q         <= sr_reg[6];
                        sr_reg      <= {sr_reg[5:0], 2'b00};
                        sym_idx_reg <= sym_idx_reg + 1'b1;
                        if (sym_idx_reg == 2'd3) begin
                            sr_full_reg   <= 1'b0;
                            bytes_out_reg <= bytes_out_reg + 1'b1;
                            if ((bytes_out_reg + 8'd1) == len_reg) begin
                                state_reg <= DONE;
                                o_done    <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
// Directed bench for qpsk_frame_ctrl (SPS=4, PRE_LEN=2). Expectations adapt to
// whether QPSK_FRAME_PREAMBLE_EN is defined for the build.
module tb_qpsk_frame_ctrl;

    localparam int SPS     = 4;
    localparam int PRE_LEN = 2;
`ifdef QPSK_FRAME_PREAMBLE_EN
    localparam int NPRE = PRE_LEN;
    localparam int BASE = 2;   // first o_valid two cycles after the start cycle
`else
    localparam int NPRE = 0;
    localparam int BASE = 3;   // extra cycle to accept the first byte
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_len = 8'd0;
    logic [7:0] i_data = 8'd0;
    logic       i_data_valid = 1'b0;
    logic       i_mod_ready = 1'b1;
    logic       o_data_ready, o_I, o_Q, o_valid, o_busy, o_done;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         acc_cyc = -1;
    int         vcyc[$];
    logic [1:0] vsym[$];
    int         dcyc[$];
    logic [7:0] feed_q[$];
    bit         feed_en = 1'b1;

    qpsk_frame_ctrl #(.SPS(SPS), .PRE_LEN(PRE_LEN)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .i_mod_ready(i_mod_ready), .o_I(o_I), .o_Q(o_Q), .o_valid(o_valid),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output recorder, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (o_valid) begin
            vcyc.push_back(cyc);
            vsym.push_back({o_I, o_Q});
        end
        if (o_done) dcyc.push_back(cyc);
    end

    // Byte feeder: presents the queue head; a byte offered while ready is high is taken
    initial forever begin
        @(negedge clk);
        if (feed_en && feed_q.size() > 0) begin
            i_data = feed_q[0];
            i_data_valid = 1'b1;
            if (o_data_ready) begin
                acc_cyc = cyc;
                void'(feed_q.pop_front());
            end
        end else begin
            i_data_valid = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_sym(input int j, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] b;
        int p;
        if (j < NPRE) return (j % 2 == 0) ? 2'b11 : 2'b00;
        p = j - NPRE;
        b = (p < 4) ? b0 : b1;
        return b[7 - 2 * (p % 4) -: 2];
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_busy"},  o_busy, 0);
        chk({tag, "_done"},  o_done, 0);
        chk({tag, "_ready"}, o_data_ready, 0);
        chk({tag, "_I"},     o_I, 0);
        chk({tag, "_Q"},     o_Q, 0);
    endtask

    task automatic start(input logic [7:0] len);
        @(negedge clk);
        vcyc.delete(); vsym.delete(); dcyc.delete();
        i_start = 1'b1; i_len = len; start_cyc = cyc;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_cond_valids(input int n, input string tag);
        int k = 0;
        while (vcyc.size() < n && k < 200) begin @(negedge clk); #1; k++; end
        chk({tag, "_reach"}, vcyc.size() >= n, 1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (dcyc.size() == 0 && k < 300) begin @(negedge clk); #1; k++; end
        chk({tag, "_done_seen"}, dcyc.size() > 0, 1);
        repeat (8) @(negedge clk);
    endtask

    // Unstalled frame: every symbol at SPS spacing from BASE, done with the last one
    task automatic check_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes, input string tag);
        int n = NPRE + 4 * nbytes;
        chk({tag, "_count"}, vcyc.size(), n);
        for (int j = 0; j < n; j++) begin
            if (j < vcyc.size()) begin
                chk($sformatf("%s_sym%0d", tag, j), vsym[j], exp_sym(j, b0, b1));
                chk($sformatf("%s_cyc%0d", tag, j), vcyc[j] - start_cyc, BASE + 4 * j);
            end
        end
        chk({tag, "_ndone"}, dcyc.size(), 1);
        if (dcyc.size() > 0) chk({tag, "_done_cyc"}, dcyc[0] - start_cyc, BASE + 4 * (n - 1));
    endtask

    initial begin
        int n0, v, a;
        // Reset state
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame A: one byte 0xB4
        feed_q.push_back(8'hB4);
        start(8'd1);
        chk("A_busy", o_busy, 1);
        wait_done("A");
        check_frame(8'hB4, 8'h00, 1, "A");
        chk("A_idle_busy", o_busy, 0);

        // Frame B: two bytes, with i_start/i_len disturbed mid-frame
        feed_q.push_back(8'h1E);
        feed_q.push_back(8'hC3);
        start(8'd2);
        repeat (7) @(negedge clk);
        i_start = 1'b1; i_len = 8'd5;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("B");
        check_frame(8'h1E, 8'hC3, 2, "B");

        // Underflow: data withheld for 10 cycles once payload wants it
        feed_en = 1'b0;
        feed_q.push_back(8'h2D);
        start(8'd1);
        begin
            int k = 0;
            while (!o_data_ready && k < 100) begin @(negedge clk); #1; k++; end
            chk("U_ready_rise", o_data_ready, 1);
        end
        n0 = vcyc.size();
        repeat (10) @(negedge clk);
        chk("U_no_valid", vcyc.size(), n0);
        chk("U_ready_held", o_data_ready, 1);
        @(posedge clk);
        feed_en = 1'b1;
        wait_done("U");
        a = acc_cyc;
        chk("U_count", vcyc.size(), NPRE + 4);
        for (int k = 0; k < 4; k++) begin
            if (NPRE + k < vcyc.size()) begin
                chk($sformatf("U_cyc%0d", k), vcyc[NPRE + k] - a, 2 + 4 * k);
                chk($sformatf("U_sym%0d", k), vsym[NPRE + k], exp_sym(NPRE + k, 8'h2D, 8'h00));
            end
        end
        if (dcyc.size() > 0) chk("U_done_cyc", dcyc[0] - a, 14);

        // Backpressure: modulator not ready for 7 cycles covering a due slot
        feed_q.push_back(8'h96);
        start(8'd1);
        wait_cond_valids(NPRE + 1, "P");
        v = vcyc[NPRE];
        i_mod_ready = 1'b0;
        repeat (7) @(negedge clk);
        i_mod_ready = 1'b1;
        wait_done("P");
        chk("P_count", vcyc.size(), NPRE + 4);
        for (int k = 1; k < 4; k++) begin
            if (NPRE + k < vcyc.size()) begin
                chk($sformatf("P_cyc%0d", k), vcyc[NPRE + k] - v, 4 + 4 * k);
                chk($sformatf("P_sym%0d", k), vsym[NPRE + k], exp_sym(NPRE + k, 8'h96, 8'h00));
            end
        end
        chk("P_ndone", dcyc.size(), 1);

        // Zero-length request is ignored
        start(8'd0);
        chk("Z_busy0", o_busy, 0);
        repeat (6) @(negedge clk);
        chk("Z_busy1", o_busy, 0);
        chk("Z_nvalid", vcyc.size(), 0);
        chk("Z_ndone", dcyc.size(), 0);

        // Reset after the third payload symbol, then a clean frame
        feed_q.push_back(8'hA5);
        feed_q.push_back(8'h3C);
        start(8'd2);
        wait_cond_valids(NPRE + 3, "R");
        rst = 1'b1;
        #1;
        chk_outputs_zero("R_rst");
        feed_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("R_no_done", dcyc.size(), 0);
        feed_q.push_back(8'h5A);
        start(8'd1);
        wait_done("R2");
        check_frame(8'h5A, 8'h00, 1, "R2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qpsk_frame_ctrl.md
QPSK_FRAME_CTRL -- requirements
Module: qpsk_frame_ctrl

Interface
REQ-001 Parameter SPS, default 4: clock cycles per symbol slot, legal range 2..16.
REQ-002 Parameter PRE_LEN, default 16: preamble length in symbols, legal range 1..64.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_start  input  1  frame request, sampled only in IDLE.
REQ-006 i_len  input  8  payload byte count, sampled with i_start; 0 = no frame.
REQ-007 i_data  input  8  payload byte.
REQ-008 i_data_valid  input  1  i_data valid.
REQ-009 o_data_ready  output  1  byte accepted when o_data_ready and i_data_valid are both high.
REQ-010 i_mod_ready  input  1  downstream modulator ready.
REQ-011 o_I / o_Q  output  1 each  symbol bits to modulator.
REQ-012 o_valid  output  1  one-cycle symbol strobe to modulator.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_done  output  1  one-cycle pulse at frame end.

Function
REQ-015 States SHALL be IDLE, PREAMBLE, PAYLOAD and DONE.
REQ-016 IDLE: i_start=1 with i_len!=0 -> PREAMBLE; i_len is latched and the slot counter is cleared. i_len=0 -> remain in IDLE with no output activity.
REQ-017 Slot counter: counts 0..SPS-1 and wraps in every non-IDLE state. A symbol issue is due when counter==0.
REQ-018 Issue condition: a symbol is issued when it is due and i_mod_ready=1 and a symbol is available.
REQ-019 If the issue condition fails while due, the counter SHALL hold at 0 (stall); no symbol is lost or duplicated.
REQ-020 On issue: o_valid=1 in the next cycle with o_I/o_Q registered. o_valid is never high two consecutive cycles.
REQ-021 PREAMBLE: symbols alternate {I,Q}=11,00,11,... starting with 11. After PRE_LEN symbols are issued -> PAYLOAD.
REQ-022 PAYLOAD holds a one-byte shift register. o_data_ready=1 only when the register is empty and fewer than the latched i_len bytes have been accepted.
REQ-023 Byte order: each byte is emitted as 4 symbols, MSB first: {I,Q}={b7,b6},{b5,b4},{b3,b2},{b1,b0}. The register empties on the 4th issue.
REQ-024 Underflow: if the register is empty when a symbol is due, this is a stall (REQ-019). Accepting a byte in that cycle makes it issuable from the next cycle.
REQ-025 After issuing 4*i_len payload symbols -> DONE. DONE lasts one cycle with o_done=1, then -> IDLE.
REQ-026 i_start outside IDLE SHALL be ignored. i_len changes mid-frame SHALL have no effect.
REQ-027 When not issuing, o_I/o_Q SHALL hold their last values.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, counters to 0, shift register empty, and o_valid=0, o_data_ready=0, o_busy=0, o_done=0, o_I=0, o_Q=0.
REQ-029 Reset mid-frame SHALL drop the partial frame. No o_done is produced for it.

Configuration
REQ-030 Macro QPSK_FRAME_PREAMBLE_EN defined: PREAMBLE state and PRE_LEN are active as specified.
REQ-031 Macro QPSK_FRAME_PREAMBLE_EN undefined: IDLE goes directly to PAYLOAD on a valid start, no preamble symbols are emitted, and PRE_LEN is ignored.

Verification
REQ-032 PREAMBLE_EN, SPS=4, PRE_LEN=2, i_len=1, byte 0xB4 present, i_mod_ready=1. Required: i_start at cycle 0 -> o_valid at cycles 2,6,10,14,18,22 with {I,Q}=11,00,10,11,01,00; o_done at the cycle after the final issue.
REQ-033 Underflow: i_data_valid withheld for 10 cycles in PAYLOAD. Required: counter holds at 0, no o_valid; the first symbol follows 1 cycle after acceptance and then resumes at SPS spacing.
REQ-034 Backpressure: i_mod_ready low for 7 cycles at a due slot. Required: no o_valid during the low period; the same symbol issues once ready returns; the total symbol count is unchanged.
REQ-035 i_len=0 with i_start -> o_busy stays 0 and no o_valid. i_start pulsed mid-frame -> frame unaffected and exactly one o_done.
REQ-036 rst asserted after the 3rd payload symbol -> all outputs are 0 in the same cycle; a new frame afterwards runs cleanly.
REQ-037 PREAMBLE_EN undefined, i_len=2 -> exactly 8 o_valid pulses, the first being payload b7/b6.
